// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 radix-2 steps per operation, one-cycle done strobe.
// Optional MULDIV_FAST_MUL_EN: multiply ops use a single-cycle combinational product.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_REM    = 3'b110;

    logic [1:0]        state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Operand conditioning for a new request
    logic            op1_signed, op2_signed, s1, s2;
    logic [XLEN-1:0] abs1, abs2;
    logic            is_div, div_zero, div_ovf;

    always_comb begin
        op1_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                     (funct3 == F3_DIV)  || (funct3 == F3_REM);
        op2_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        s1         = op1_signed && op1[XLEN-1];
        s2         = op2_signed && op2[XLEN-1];
        abs1       = s1 ? -op1 : op1;
        abs2       = s2 ? -op2 : op2;
        is_div     = funct3[2];
        div_zero   = is_div && (op2 == '0);
        div_ovf    = is_div && !funct3[0] &&
                     (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fast_m1, fast_m2, fast_prod;

    always_comb begin
        fast_m1   = {{XLEN{op1_signed && op1[XLEN-1]}}, op1};
        fast_m2   = {{XLEN{op2_signed && op2[XLEN-1]}}, op2};
        fast_prod = fast_m1 * fast_m2;
    end
`endif

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    // Divide keeps the partial remainder in acc[63:32] and the quotient in acc[31:0].
    logic [2*XLEN-1:0] mul_acc, step_acc, prod_fix;
    logic [XLEN:0]     div_shift, div_sub;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem, quo_fix, rem_fix, final_val;
    logic [4:0]        bit_idx;

    always_comb begin
        bit_idx   = 5'd31 - cnt_q[4:0];
        mul_acc   = acc_q + (b_q[cnt_q[4:0]] ? ({{XLEN{1'b0}}, a_q} << cnt_q[4:0]) : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], a_q[bit_idx]};
        div_sub   = div_shift - {1'b0, b_q};
        div_ge    = !div_sub[XLEN];
        div_rem   = div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0];
        step_acc  = f3_q[2] ? {div_rem, acc_q[XLEN-2:0], div_ge} : mul_acc;

        prod_fix  = neg_q  ? -step_acc : step_acc;
        quo_fix   = neg_q  ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
        rem_fix   = rneg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];

        case (f3_q)
            F3_MUL:         final_val = prod_fix[XLEN-1:0];
            3'b100, 3'b101: final_val = quo_fix;
            3'b110, 3'b111: final_val = rem_fix;
            default:        final_val = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block leaves a latch.
        state_d  = state_q;
        f3_d     = f3_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (div_zero) begin
                            result_d = funct3[1] ? op1 : '1;
                            state_d  = ST_DONE;
                        end else if (div_ovf) begin
                            result_d = funct3[1] ? '0 : op1;
                            state_d  = ST_DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!is_div) begin
                            result_d = (funct3 == F3_MUL) ? fast_prod[XLEN-1:0]
                                                          : fast_prod[2*XLEN-1:XLEN];
                            state_d  = ST_DONE;
`endif
                        end else begin
                            f3_d    = funct3;
                            a_d     = abs1;
                            b_d     = abs2;
                            neg_d   = s1 ^ s2;
                            rneg_d  = s1;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        result_d = final_val;
                        state_d  = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= ST_IDLE;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule
